// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and forwarding-select codes for hazard_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - EX-stage forward select for one source operand
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    // x0 is hardwired zero, so a producer targeting it never forwards
    always_comb begin
        fwd_o = FWD_REG;
        if (rs_i != 5'd0) begin
            if (reg_write_m_i && (rd_m_i == rs_i)) begin
                fwd_o = FWD_MEM;
            end else if (reg_write_w_i && (rd_w_i == rs_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with forwarding, dmem wait FSM and perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = $clog2(MAX_WAIT) + 1;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lw_stall;
    logic dwait;
    logic branch_flush;

    fwd_sel u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardBE)
    );

    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign dwait    = ((state_q == ST_RUN) && dmem_req && !dmem_ready) || (state_q == ST_DWAIT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d    = ST_DWAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            ST_DWAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WCW'(MAX_WAIT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_ERR:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Held in reset, every pipeline control reads as a plain advance regardless of inputs
    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushW       = 1'b0;
        branch_flush = 1'b0;
        if (!reset) begin
            if (dwait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                FlushW = (state_q == ST_ERR);
                if (PCSrcE) begin
                    FlushD       = 1'b1;
                    FlushE       = 1'b1;
                    branch_flush = 1'b1;
                end else begin
                    if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                    if (!imem_ready) begin
                        StallF = 1'b1;
                        FlushD = !lw_stall;
                    end
                end
            end
        end
    end

    assign bus_err   = (state_q == ST_ERR) && !reset;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, imem_ready, dmem_req, dmem_ready;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, bus_err;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .bus_err(bus_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: is an access pending, how long has it been frozen, abort cycle, event totals
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_abort   = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    typedef struct packed {
        logic sf, sd, se, sm, fd, fe, fw, be, br;
        logic [1:0] fa, fb;
    } exp_t;

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit lw, frozen;
        e = '0;
        e.fa = fwd_of(Rs1E);
        e.fb = fwd_of(Rs2E);
        if (reset) return e;
        lw = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        frozen = m_waiting || (!m_abort && dmem_req && !dmem_ready);
        e.be = m_abort;
        if (frozen) begin
            {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
        end else begin
            e.fw = m_abort;
            if (PCSrcE) begin
                e.fd = 1; e.fe = 1; e.br = 1;
            end else begin
                if (lw) begin e.sf = 1; e.sd = 1; e.fe = 1; end
                if (!imem_ready) begin e.sf = 1; e.fd = !lw; end
            end
        end
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            m_waiting <= 0; m_waited <= 0; m_abort <= 0; m_stalls <= 0; m_flushes <= 0;
        end else begin
            e = model_out();
            m_stalls  <= (e.sf && m_stalls < CNT_MAX) ? m_stalls + 1 : m_stalls;
            m_flushes <= (e.br && m_flushes < CNT_MAX) ? m_flushes + 1 : m_flushes;
            if (m_abort) begin
                m_abort <= 0;
            end else if (m_waiting) begin
                if (dmem_ready) m_waiting <= 0;
                else if (m_waited + 1 == MAX_WAIT) begin m_waiting <= 0; m_abort <= 1; end
                else m_waited <= m_waited + 1;
            end else if (dmem_req && !dmem_ready) begin
                m_waiting <= 1; m_waited <= 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = model_out();
        chk("m_StallF", StallF, e.sf);
        chk("m_StallD", StallD, e.sd);
        chk("m_StallE", StallE, e.se);
        chk("m_StallM", StallM, e.sm);
        chk("m_FlushD", FlushD, e.fd);
        chk("m_FlushE", FlushE, e.fe);
        chk("m_FlushW", FlushW, e.fw);
        chk("m_FwdA", ForwardAE, e.fa);
        chk("m_FwdB", ForwardBE, e.fb);
        chk("m_bus_err", bus_err, e.be);
        chk("m_stall_cnt", stall_cnt, m_stalls);
        chk("m_flush_cnt", flush_cnt, m_flushes);
    end

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        imem_ready = 1; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        next();
        next();
        reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;
        next();
        @(negedge clk);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_StallF", StallF, 0);
        next();
        reset = 0;

        // idle
        @(negedge clk);
        chk("idle_StallF", StallF, 0);
        chk("idle_FlushD", FlushD, 0);
        chk("idle_FwdA", ForwardAE, 0);
        chk("idle_flush_cnt", flush_cnt, 0);

        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        next();
        ResultSrcE0 = 1; RdE = 5; Rs1D = 5; Rs2D = 1;
        @(negedge clk);
        chk("lu_stalls", {StallF, StallD, FlushE, FlushD}, 4'b1110);
        next();
        ResultSrcE0 = 0; RdE = 0; RdM = 5; RegWriteM = 1;
        @(negedge clk);
        chk("lu_release", {StallF, StallD, FlushE}, 3'b000);
        next();
        Rs1E = 5; Rs2E = 1; RdM = 0; RegWriteM = 0; RdW = 5; RegWriteW = 1; Rs1D = 0; Rs2D = 0;
        @(negedge clk);
        chk("lu_FwdA_wb", ForwardAE, 2'b01);
        chk("lu_FwdB_reg", ForwardBE, 2'b00);
        chk("lu_stall_cnt", stall_cnt, 1);

        // forwarding priority and x0
        next();
        RegWriteM = 1; RegWriteW = 1; RdM = 3; RdW = 3; Rs1E = 3; Rs2E = 3;
        @(negedge clk);
        chk("fw_mem_wins_A", ForwardAE, 2'b10);
        chk("fw_mem_wins_B", ForwardBE, 2'b10);
        next();
        Rs1E = 0;
        @(negedge clk);
        chk("fw_x0", ForwardAE, 2'b00);
        next();
        RegWriteM = 0;
        @(negedge clk);
        chk("fw_wb_only", ForwardBE, 2'b01);

        // branch overrides load-use and fetch wait
        next();
        idle();
        PCSrcE = 1; ResultSrcE0 = 1; RdE = 5; Rs1D = 5; imem_ready = 0;
        @(negedge clk);
        chk("br_ctrl", {FlushD, FlushE, StallF, StallD}, 4'b1100);
        next();
        PCSrcE = 0;
        @(negedge clk);
        chk("lu_imem_ctrl", {StallF, StallD, FlushE, FlushD}, 4'b1110);
        chk("br_flush_cnt", flush_cnt, 1);
        next();
        ResultSrcE0 = 0;
        @(negedge clk);
        chk("imem_ctrl", {StallF, StallD, FlushE, FlushD}, 4'b1001);
        chk("imem_stall_cnt", stall_cnt, 2);

        // data wait with completion, branch frozen meanwhile
        next();
        do_reset();
        dmem_req = 1; dmem_ready = 1;
        @(negedge clk);
        chk("zw_no_stall", {StallF, StallM, FlushW}, 3'b000);
        next();
        dmem_ready = 0; PCSrcE = 1;
        @(negedge clk);
        chk("dw_frozen", {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}, 7'b1111100);
        next();
        next();
        dmem_ready = 1;
        @(negedge clk);
        chk("dw_last", {StallF, StallM, FlushW}, 3'b111);
        next();
        dmem_req = 0; dmem_ready = 0; PCSrcE = 0;
        @(negedge clk);
        chk("dw_done", StallF, 0);
        chk("dw_stall_cnt", stall_cnt, 3);
        chk("dw_flush_cnt", flush_cnt, 0);

        // timeout abort; stall_cnt saturates
        next();
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            chk("to_frozen", {StallM, bus_err}, 2'b10);
            next();
        end
        PCSrcE = 1;
        @(negedge clk);
        chk("to_err", {bus_err, FlushW, StallF, StallM, FlushD}, 5'b11001);
        chk("to_stall_sat", stall_cnt, CNT_MAX);
        next();
        dmem_req = 0; PCSrcE = 0;
        @(negedge clk);
        chk("to_run", {bus_err, FlushW, StallF}, 3'b000);
        chk("to_flush_cnt", flush_cnt, 1);

        // reset in the middle of a wait
        next();
        dmem_req = 1;
        next();
        next();
        reset = 1;
        @(negedge clk);
        chk("mr_outputs", {StallF, StallM, FlushW, bus_err}, 4'b0000);
        next();
        reset = 0; dmem_req = 0;
        @(negedge clk);
        chk("mr_run", {StallF, StallM}, 2'b00);
        chk("mr_cnt", stall_cnt, 0);
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
